baud_rate_controller: RTL and testbench
=======================================

# baud_rate_controller

Configuration and sequencing controller for the UART baud clock. Accepts a requested baud rate over a valid/ready handshake and computes the rounded 16x-oversample divisor from the system clock frequency with a multi-cycle divider. It defers the divisor swap until the TX/RX datapaths report idle, then drives the single-cycle oversample and bit ticks consumed by the UART transmitter and receiver.

## Interface
Parameters:
- RESET_DIVISOR, 27, active divisor after reset (115200 baud at 50 MHz); must be ≥1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clk_freq  in  32  system clock frequency in Hz; sampled on handshake
- baud_rate  in  32  requested baud rate in baud/s; sampled on handshake
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  controller can accept a request
- busy_in  in  1  high while any frame is in flight in TX or RX
- enable  in  1  tick generation enable
- divisor  out  32  currently active divisor
- os_tick  out  1  one-cycle pulse at 16x baud
- baud_tick  out  1  one-cycle pulse at 1x baud
- locked  out  1  no reconfiguration pending
- cfg_error  out  1  sticky: last request was invalid

## Operation
- FSM states: IDLE, CALC, WAIT_IDLE, APPLY.
- IDLE: cfg_ready=1. On cfg_valid&&cfg_ready, latch inputs, clear cfg_error, set locked=0.
  - baud_rate==0: set cfg_error=1 and locked=1, stay in IDLE.
  - Otherwise go to CALC.
- CALC: 36-iteration restoring unsigned division, one quotient bit per cycle. 36-bit numerator = clk_freq + (baud_rate<<3); 36-bit denominator = baud_rate<<4. Result is round-to-nearest of clk_freq/(16·baud_rate).
  - Quotient==0: cfg_error=1, locked=1, go to IDLE; divisor unchanged.
  - Quotient ≥2^32: saturate to 0xFFFF_FFFF.
  - Otherwise go to WAIT_IDLE.
- WAIT_IDLE: hold the result. Go to APPLY in the first cycle busy_in==0 (zero wait if already low).
- APPLY: one cycle. Load divisor, clear both tick counters, set locked=1, go to IDLE.
- Tick generation, when enable=1:
  - os_cnt counts 0..divisor-1. os_tick=1 in the cycle os_cnt==divisor-1.
  - sub_cnt (4 bits) increments on each os_tick. baud_tick=1 coincident with the os_tick where sub_cnt==15.
  - divisor==1 gives os_tick every cycle.
- enable=0: counters forced to 0, no ticks. The configuration FSM keeps running.
- cfg_valid outside IDLE is ignored; the requester must hold it.

## Timing
- Reset values: cfg_ready=1, divisor=RESET_DIVISOR, os_tick=0, baud_tick=0, locked=1, cfg_error=0, FSM=IDLE, counters=0.
- Handshake at edge T: cfg_ready=0 and locked=0 from T+1. Cycles T+1..T+36 are CALC.
- With busy_in low: WAIT_IDLE at T+37, APPLY at T+38. New divisor, locked=1 and cfg_ready=1 are visible from T+39.
- Zero-baud error: cfg_error=1 at T+1, cfg_ready remains 1.
- Ticks use the old divisor until APPLY. The first tick with the new divisor comes new_divisor cycles after APPLY.
- busy_in toggling during CALC has no effect. Only its level in WAIT_IDLE matters.
- rst mid-operation aborts CALC or WAIT_IDLE immediately and restores the reset values. The pending result is discarded.
- All outputs are registered.

## Structure
- uart_pkg: FSM state enum, OS_RATIO=16, DIV_W=36, ITER_W=6.
- Sub-module seq_divider: start/done, 36-bit restoring divider, one bit per cycle. The controller's CALC state maps to its busy period.

## Test plan
- Reset, enable=1, no config -> os_tick period 27 cycles; baud_tick every 432 cycles; locked=1, divisor=27.
- clk_freq=50_000_000, baud_rate=9600, busy_in=0 -> divisor=326 at T+39; os_tick period 326; baud_tick period 5216.
- Same request with busy_in=1 until T+100 -> state stays WAIT_IDLE and ticks keep period 27 until busy_in falls; divisor=326 two cycles later.
- baud_rate=0 -> cfg_error=1 at T+1, divisor unchanged. Next valid request (115200) clears cfg_error and yields divisor=27.
- clk_freq=1000, baud_rate=115200 -> quotient 0, cfg_error=1, locked=1 after CALC. cfg_valid pulsed during CALC is not accepted.
- rst asserted at T+20 mid-CALC -> all reset values restored asynchronously; ticks resume with period 27 after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART baud-rate controller and its divider.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CALC      = 2'd1,
      WAIT_IDLE = 2'd2,
      APPLY     = 2'd3
   } state_t;

   localparam int OS_RATIO = 16;
   localparam int SUB_W    = $clog2(OS_RATIO);
   localparam int DIV_W    = 36;
   localparam int ITER_W   = 6;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per cycle over DIV_W cycles.
module seq_divider
   import uart_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] numerator,
   input  logic [DIV_W-1:0] denominator,
   output logic             done,
   output logic [DIV_W-1:0] quotient
);

   logic              active;
   logic [ITER_W-1:0] iter;
   logic [DIV_W-1:0]  num_sh;
   logic [DIV_W-1:0]  den;
   logic [DIV_W-1:0]  rem;
   logic [DIV_W-2:0]  quo;
   logic [DIV_W:0]    trial;
   logic [DIV_W-1:0]  rem_nxt;
   logic              fits;

   // The true remainder is always below den, so the low DIV_W bits of the
   // subtraction are exact even though trial is one bit wider.
   always_comb begin
      trial   = {rem, num_sh[DIV_W-1]};
      fits    = (trial >= {1'b0, den});
      rem_nxt = fits ? (trial[DIV_W-1:0] - den) : trial[DIV_W-1:0];
   end

   assign done     = active && (iter == ITER_W'(DIV_W - 1));
   assign quotient = {quo, fits};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active <= 1'b0;
         iter   <= '0;
         num_sh <= '0;
         den    <= '0;
         rem    <= '0;
         quo    <= '0;
      end else if (start) begin
         active <= 1'b1;
         iter   <= '0;
         num_sh <= numerator;
         den    <= denominator;
         rem    <= '0;
         quo    <= '0;
      end else if (active) begin
         num_sh <= num_sh << 1;
         rem    <= rem_nxt;
         quo    <= quotient[DIV_W-2:0];
         iter   <= iter + ITER_W'(1);
         if (done) active <= 1'b0;
      end
   end

endmodule

// File: rtl/baud_rate_controller.sv
// Baud clock controller: computes a rounded 16x divisor on request, swaps it in
// once TX/RX are idle, and generates the oversample and bit ticks.
module baud_rate_controller
   import uart_pkg::*;
#(
   parameter logic [31:0] RESET_DIVISOR = 32'd27
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] clk_freq,
   input  logic [31:0] baud_rate,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic        busy_in,
   input  logic        enable,
   output logic [31:0] divisor,
   output logic        os_tick,
   output logic        baud_tick,
   output logic        locked,
   output logic        cfg_error,
   output logic [1:0]  fsm_state
);

   // Handshake: a request is taken on any rising edge where cfg_valid and
   // cfg_ready are both high; cfg_valid seen while cfg_ready is low is ignored.

   state_t           state, state_nxt;
   logic [31:0]      pending;
   logic [31:0]      os_cnt, cnt_nxt, div_nxt;
   logic [SUB_W-1:0] sub_cnt, sub_base, sub_nxt;
   logic             tick_nxt, baud_nxt;
   logic             accept, div_start, div_done, apply, quot_zero;
   logic [DIV_W-1:0] numerator, denominator, quotient;
   logic [31:0]      quot_sat;

   assign accept      = cfg_valid && cfg_ready;
   assign div_start   = accept && (baud_rate != 32'd0);
   // Adding half the denominator turns the truncating divide into round-to-nearest.
   assign numerator   = {4'd0, clk_freq} + {1'b0, baud_rate, 3'd0};
   assign denominator = {baud_rate, 4'd0};
   assign quot_zero   = (quotient == '0);
   assign quot_sat    = (|quotient[DIV_W-1:32]) ? 32'hFFFF_FFFF : quotient[31:0];
   assign apply       = (state == APPLY);
   assign fsm_state   = state;

   seq_divider u_div (
      .clk         (clk),
      .rst         (rst),
      .start       (div_start),
      .numerator   (numerator),
      .denominator (denominator),
      .done        (div_done),
      .quotient    (quotient)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept) state_nxt = (baud_rate == 32'd0) ? IDLE : CALC;
         CALC:      if (div_done) state_nxt = quot_zero ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (!busy_in) state_nxt = APPLY;
         APPLY:     state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cfg_ready <= 1'b1;
         pending   <= RESET_DIVISOR;
         divisor   <= RESET_DIVISOR;
         locked    <= 1'b1;
         cfg_error <= 1'b0;
      end else begin
         state     <= state_nxt;
         cfg_ready <= (state_nxt == IDLE);
         if (accept) begin
            cfg_error <= (baud_rate == 32'd0);
            locked    <= (baud_rate == 32'd0);
         end
         if ((state == CALC) && div_done) begin
            if (quot_zero) begin
               cfg_error <= 1'b1;
               locked    <= 1'b1;
            end else begin
               pending <= quot_sat;
            end
         end
         if (apply) begin
            divisor <= pending;
            locked  <= 1'b1;
         end
      end
   end

   // Ticks are registered from the counter value of the coming cycle, so on
   // APPLY the fresh divisor and cleared counters are already taken into account.
   always_comb begin
      div_nxt  = apply ? pending : divisor;
      sub_base = apply ? '0 : sub_cnt;
      cnt_nxt  = '0;
      if (enable && !apply && (os_cnt < divisor - 32'd1)) cnt_nxt = os_cnt + 32'd1;
      tick_nxt = enable && (cnt_nxt == div_nxt - 32'd1);
      baud_nxt = tick_nxt && (sub_base == SUB_W'(OS_RATIO - 1));
      sub_nxt  = '0;
      if (enable) sub_nxt = tick_nxt ? sub_base + SUB_W'(1) : sub_base;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         os_cnt    <= '0;
         sub_cnt   <= '0;
         os_tick   <= 1'b0;
         baud_tick <= 1'b0;
      end else begin
         os_cnt    <= cnt_nxt;
         sub_cnt   <= sub_nxt;
         os_tick   <= tick_nxt;
         baud_tick <= baud_nxt;
      end
   end

endmodule

// File: tb/tb_baud_rate_controller.sv
// Self-checking bench for baud_rate_controller: table-driven configuration
// requests plus hand-written busy, error, enable and reset sequences.
module tb_baud_rate_controller;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] clk_freq;
   logic [31:0] baud_rate;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        busy_in;
   logic        enable;
   logic [31:0] divisor;
   logic        os_tick;
   logic        baud_tick;
   logic        locked;
   logic        cfg_error;
   logic [1:0]  fsm_state;

   typedef struct {
      logic [31:0] clk_freq;
      logic [31:0] baud;
      logic        exp_err;
      logic [31:0] exp_div;
   } vec_t;

   vec_t        vecs[10];
   logic [31:0] exp_q[$];
   logic [31:0] model_div;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   baud_rate_controller #(.RESET_DIVISOR(32'd27)) dut (
      .clk       (clk),
      .rst       (rst),
      .clk_freq  (clk_freq),
      .baud_rate (baud_rate),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .busy_in   (busy_in),
      .enable    (enable),
      .divisor   (divisor),
      .os_tick   (os_tick),
      .baud_tick (baud_tick),
      .locked    (locked),
      .cfg_error (cfg_error),
      .fsm_state (fsm_state)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_q(input logic [31:0] f, input logic [31:0] b);
      longint unsigned n, d, q;
      n = 64'(f) + 64'(b) * 8;
      d = 64'(b) * 16;
      q = n / d;
      return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
   endfunction

   task automatic check_period(input string name, input bit use_baud, input int exp_p);
      int n;
      int limit;
      limit = exp_p * 3 + 50;
      n = 0;
      while (!(use_baud ? baud_tick : os_tick) && n < limit) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(use_baud ? baud_tick : os_tick) && n < limit);
      check(name, n, exp_p);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_divisor"}, divisor, 27);
      check({tag, "_locked"}, locked, 1);
      check({tag, "_ready"}, cfg_ready, 1);
      check({tag, "_err"}, cfg_error, 0);
      check({tag, "_os_tick"}, os_tick, 0);
      check({tag, "_baud_tick"}, baud_tick, 0);
      check({tag, "_state"}, fsm_state, IDLE);
   endtask

   task automatic do_cfg(input vec_t v);
      int          edges;
      int          k;
      logic [31:0] exp_div;
      exp_div = v.exp_err ? model_div : v.exp_div;
      exp_q.push_back(exp_div);
      @(negedge clk);
      clk_freq  = v.clk_freq;
      baud_rate = v.baud;
      cfg_valid = 1'b1;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
      edges = 1;
      @(negedge clk);
      if (v.baud == 32'd0) begin
         check("zero_err", cfg_error, 1);
         check("zero_ready", cfg_ready, 1);
         check("zero_locked", locked, 1);
      end else begin
         check("hs_ready", cfg_ready, 0);
         check("hs_locked", locked, 0);
         check("hs_err_clr", cfg_error, 0);
         while (!locked && edges < 100) begin
            @(negedge clk);
            edges++;
         end
         check("latency", edges, v.exp_err ? 37 : 39);
         check("err", cfg_error, v.exp_err);
         check("ready_after", cfg_ready, 1);
      end
      check("divisor", divisor, exp_q.pop_front());
      model_div = exp_div;
      if (!v.exp_err && exp_div <= 1000) begin
         k = 0;
         while (!os_tick && k < int'(exp_div) + 5) begin
            @(negedge clk);
            k++;
         end
         check("first_tick", k, exp_div - 1);
         check_period("os_period", 1'b0, int'(exp_div));
         if (exp_div * 16 <= 6000) check_period("baud_period", 1'b1, int'(exp_div) * 16);
      end
   endtask

   initial begin
      vec_t r;
      int   edges;
      int   ticks;
      vecs[0] = '{32'd50_000_000, 32'd9600,      1'b0, 32'd326};
      vecs[1] = '{32'd50_000_000, 32'd0,         1'b1, 32'd0};
      vecs[2] = '{32'd50_000_000, 32'd115200,    1'b0, 32'd27};
      vecs[3] = '{32'd1000,       32'd115200,    1'b1, 32'd0};
      vecs[4] = '{32'd100_000_000, 32'd9600,     1'b0, 32'd651};
      vecs[5] = '{32'd48_000_000, 32'd3_000_000, 1'b0, 32'd1};
      vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'd0};
      vecs[7] = '{32'd24,         32'd1,         1'b0, 32'd2};
      vecs[8] = '{32'd50_000_000, 32'd1,         1'b0, 32'd3_125_000};
      vecs[9] = '{32'd16,         32'd1,         1'b0, 32'd1};

      // clock/reset
      rst = 1'b1; clk_freq = '0; baud_rate = '0; cfg_valid = 1'b0;
      busy_in = 1'b0; enable = 1'b1; model_div = 32'd27;
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      rst = 1'b0;
      check_period("rst_os_period", 1'b0, 27);
      check_period("rst_baud_period", 1'b1, 432);

      for (int i = 0; i < 10; i++) do_cfg(vecs[i]);

      // Zero quotient, with a cfg_valid pulse during CALC that must be ignored
      @(negedge clk);
      clk_freq = 32'd1000; baud_rate = 32'd115200; cfg_valid = 1'b1;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
      edges = 0;
      repeat (10) begin @(negedge clk); edges++; end
      check("q0_calc_state", fsm_state, CALC);
      check("q0_calc_ready", cfg_ready, 0);
      clk_freq = 32'd50_000_000; baud_rate = 32'd9600; cfg_valid = 1'b1;
      @(negedge clk);
      edges++;
      cfg_valid = 1'b0;
      while (!cfg_error && edges < 100) begin @(negedge clk); edges++; end
      check("q0_latency", edges, 37);
      check("q0_locked", locked, 1);
      check("q0_divisor", divisor, model_div);
      repeat (3) @(negedge clk);
      check("q0_no_accept_state", fsm_state, IDLE);
      check("q0_no_accept_divisor", divisor, model_div);

      // enable low suppresses ticks
      enable = 1'b0;
      ticks = 0;
      repeat (60) begin
         @(negedge clk);
         if (os_tick || baud_tick) ticks++;
      end
      check("disabled_ticks", ticks, 0);
      enable = 1'b1;
      check_period("reenable_os_period", 1'b0, int'(model_div));

      // random requests against the arithmetic model
      for (int i = 0; i < 3; i++) begin
         r.clk_freq = $urandom_range(100_000_000, 1_000_000);
         r.baud     = $urandom_range(1_000_000, 300);
         r.exp_div  = model_q(r.clk_freq, r.baud);
         r.exp_err  = (r.exp_div == 32'd0);
         do_cfg(r);
      end

      // Deferred swap while busy_in is high
      do_cfg(vecs[2]);
      busy_in = 1'b1;
      @(negedge clk);
      clk_freq = 32'd50_000_000; baud_rate = 32'd9600; cfg_valid = 1'b1;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
      edges = 0;
      repeat (30) begin
         @(negedge clk);
         edges++;
         busy_in = 1'($urandom_range(1, 0));
      end
      busy_in = 1'b1;
      while (edges < 45) begin @(negedge clk); edges++; end
      check("busy_state", fsm_state, WAIT_IDLE);
      check("busy_locked", locked, 0);
      check("busy_old_divisor", divisor, 27);
      check_period("busy_old_os_period", 1'b0, 27);
      check("busy_state_late", fsm_state, WAIT_IDLE);
      busy_in = 1'b0;
      @(negedge clk);
      check("busy_apply_state", fsm_state, APPLY);
      check("busy_apply_locked", locked, 0);
      @(negedge clk);
      check("busy_new_divisor", divisor, 326);
      check("busy_new_locked", locked, 1);
      model_div = 32'd326;
      check_period("busy_new_os_period", 1'b0, 326);

      // Asynchronous reset in the middle of CALC
      @(negedge clk);
      clk_freq = 32'd100_000_000; baud_rate = 32'd9600; cfg_valid = 1'b1;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      @(negedge clk);
      rst = 1'b0;
      model_div = 32'd27;
      check_period("post_rst_os_period", 1'b0, 27);
      repeat (50) @(negedge clk);
      check("post_rst_divisor", divisor, 27);
      check("post_rst_locked", locked, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
